priority_encoder_8to3: RTL and testbench

- Registered 8-line-to-3-bit priority encoder, 74148-style: active-low request lines in, binary index of the highest pending request out.
- It is the encode direction paired with the team's 3-to-8 decoders, so a decoder on the far side can regenerate the one-hot line.
- Requests are synchronised, latched as pending, and handed out one at a time over a valid/ready handshake.
- Cascade pins (ei_n_i, eo_n_o, gs_n_o) allow chaining two or more instances.

---
 rtl/priority_encoder_8to3_pkg.sv | 29 ++
 rtl/priority_encoder_8to3_sync_chain.sv | 31 +++
 rtl/priority_encoder_8to3.sv | 121 ++++++++++++
 tb/tb_priority_encoder_8to3.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/priority_encoder_8to3_pkg.sv
// Shared constants and helpers for the 8-to-3 priority encoder.
// prio_idx picks the highest set line; idx2onehot is the inverse mapping,
// matching the team's 3-to-8 decoders.
package prio_enc_pkg;

    localparam int NUM_LINES = 8;
    localparam int CODE_W    = 3;

    // Index of the highest set bit; 0 when the vector is empty.
    function automatic logic [CODE_W-1:0] prio_idx(input logic [NUM_LINES-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (v[i]) begin
                idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

    // One-hot line for a binary index.
    function automatic logic [NUM_LINES-1:0] idx2onehot(input logic [CODE_W-1:0] idx);
        logic [NUM_LINES-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/priority_encoder_8to3_sync_chain.sv
// Multi-flop synchroniser for asynchronous active-low lines.
// Resets to all-ones so idle (high) request lines never look like a fall.
module sync_chain #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift the raw lines through DEPTH flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '1;
            end
        end else begin
            r_stage[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q_o = r_stage[DEPTH-1];

endmodule

// File: rtl/priority_encoder_8to3.sv
// Registered 74148-style priority encoder with pending latch, valid/ready
// hand-out of the highest pending line, cascade pins and sticky overflow.
module priority_encoder_8to3
    import prio_enc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_LINES-1:0] in_n_i,
    input  logic                 ei_n_i,
    input  logic                 ready_i,
    input  logic                 ovf_clr_i,
    output logic                 valid_o,
    output logic [CODE_W-1:0]    code_o,
    output logic [CODE_W-1:0]    a_n_o,
    output logic                 gs_n_o,
    output logic                 eo_n_o,
    output logic [NUM_LINES-1:0] ovf_o
);

    logic [NUM_LINES-1:0] w_sync;
    logic [NUM_LINES-1:0] w_evt;
    logic                 w_acc;
    logic [NUM_LINES-1:0] w_clr;
    logic [NUM_LINES-1:0] w_avail;
    logic [NUM_LINES-1:0] w_pend_next;
    logic [NUM_LINES-1:0] w_ovf_next;
    logic                 w_valid_next;
    logic [CODE_W-1:0]    w_code_next;
    logic                 w_eo_next;

    logic [NUM_LINES-1:0] r_prev;
    logic [NUM_LINES-1:0] r_pend;
    logic [NUM_LINES-1:0] r_ovf;
    logic                 r_valid;
    logic [CODE_W-1:0]    r_code;
    logic [CODE_W-1:0]    r_a_n;
    logic                 r_gs_n;
    logic                 r_eo_n;

    sync_chain #(
        .WIDTH (NUM_LINES),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (in_n_i),
        .q_o   (w_sync)
    );

    // Next-state for pending, overflow and the presented code.
    always_comb begin
        w_acc = r_valid & ready_i;
        w_clr = w_acc ? idx2onehot(r_code) : '0;

        // Edge mode: a high-to-low transition; level mode: any low line.
        if (EDGE_MODE != 0) begin
            w_evt = r_prev & ~w_sync;
        end else begin
            w_evt = ~w_sync;
        end

        // The accepted line is dropped first; fresh events join afterwards,
        // so they become presentable only on the following cycle.
        w_avail     = r_pend & ~w_clr;
        w_pend_next = w_avail | w_evt;

        // A second event on a still-pending line is lost; flag it.
        // A new set beats a simultaneous clear.
        w_ovf_next = ovf_clr_i ? '0 : r_ovf;
        if (EDGE_MODE != 0) begin
            w_ovf_next = w_ovf_next | (w_evt & r_pend & ~w_clr);
        end

        // The code only moves when idle or on an accept, which keeps it
        // stable while the consumer stalls.
        w_valid_next = r_valid;
        w_code_next  = r_code;
        if (ei_n_i) begin
            w_valid_next = 1'b0;
        end else if (!r_valid || w_acc) begin
            w_valid_next = |w_avail;
            w_code_next  = prio_idx(w_avail);
        end

        w_eo_next = ei_n_i | (|w_pend_next) | w_valid_next;
    end

    // State and registered 74148-compatible outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prev  <= '1;
            r_pend  <= '0;
            r_ovf   <= '0;
            r_valid <= 1'b0;
            r_code  <= '0;
            r_a_n   <= '1;
            r_gs_n  <= 1'b1;
            r_eo_n  <= 1'b1;
        end else begin
            r_prev  <= w_sync;
            r_pend  <= w_pend_next;
            r_ovf   <= w_ovf_next;
            r_valid <= w_valid_next;
            r_code  <= w_code_next;
            r_a_n   <= w_valid_next ? ~w_code_next : '1;
            r_gs_n  <= ~w_valid_next;
            r_eo_n  <= w_eo_next;
        end
    end

    assign valid_o = r_valid;
    assign code_o  = r_code;
    assign a_n_o   = r_a_n;
    assign gs_n_o  = r_gs_n;
    assign eo_n_o  = r_eo_n;
    assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Bench for priority_encoder_8to3: directed scenarios followed by random
// traffic, all compared against a line-by-line behavioural model.
module tb_priority_encoder_8to3;

    localparam int SYNC = 2;
    localparam int EDGE = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_n;
    logic       ei_n;
    logic       ready;
    logic       ovf_clr;
    logic       valid_o;
    logic [2:0] code_o;
    logic [2:0] a_n_o;
    logic       gs_n_o;
    logic       eo_n_o;
    logic [7:0] ovf_o;

    int checks   = 0;
    int failures = 0;

    // model state
    bit [7:0] q[$];
    bit [7:0] m_prev;
    bit [7:0] m_pend;
    bit [7:0] m_ovf;
    bit       m_valid;
    int       m_code;
    bit       m_eo;

    priority_encoder_8to3 #(
        .SYNC_STAGES (SYNC),
        .EDGE_MODE   (EDGE)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .in_n_i    (in_n),
        .ei_n_i    (ei_n),
        .ready_i   (ready),
        .ovf_clr_i (ovf_clr),
        .valid_o   (valid_o),
        .code_o    (code_o),
        .a_n_o     (a_n_o),
        .gs_n_o    (gs_n_o),
        .eo_n_o    (eo_n_o),
        .ovf_o     (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < SYNC; i++) q.push_back(8'hFF);
        m_prev  = 8'hFF;
        m_pend  = '0;
        m_ovf   = '0;
        m_valid = 0;
        m_code  = 0;
        m_eo    = 1;
    endtask

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_step();
        bit [7:0] s;
        bit [7:0] evt;
        bit [7:0] avail;
        bit       acc;
        int       al;
        if (rst) begin
            model_reset();
            return;
        end
        s = q[0];
        for (int i = 0; i < 8; i++)
            evt[i] = (EDGE != 0) ? (m_prev[i] && !s[i]) : !s[i];
        acc = m_valid && ready;
        al  = m_code;
        for (int i = 0; i < 8; i++) begin
            if (EDGE != 0 && evt[i] && m_pend[i] && !(acc && al == i)) m_ovf[i] = 1;
            else if (ovf_clr) m_ovf[i] = 0;
        end
        if (acc) m_pend[al] = 0;
        avail = m_pend;
        for (int i = 0; i < 8; i++) if (evt[i]) m_pend[i] = 1;
        if (ei_n) begin
            m_valid = 0;
        end else if (!m_valid || acc) begin
            m_valid = 0;
            m_code  = 0;
            for (int i = 7; i >= 0; i--) begin
                if (avail[i]) begin
                    m_valid = 1;
                    m_code  = i;
                    break;
                end
            end
        end
        m_eo = ei_n || (m_pend != 0) || m_valid;
        m_prev = s;
        q.push_back(in_n);
        void'(q.pop_front());
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, valid_o, m_valid);
        if (m_valid) chk({tag, "_code"}, code_o, m_code);
        chk({tag, "_a_n"}, a_n_o, m_valid ? 32'(7 - m_code) : 32'd7);
        chk({tag, "_gs_n"}, gs_n_o, !m_valid);
        chk({tag, "_eo_n"}, eo_n_o, m_eo);
        chk({tag, "_ovf"}, ovf_o, m_ovf);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_lines(input int n);
        in_n = 8'hFF;
        for (int i = 0; i < n; i++) tick("idle");
    endtask

    int codes[$];
    int cnt5;

    initial begin
        rst = 1; in_n = 8'hFF; ei_n = 0; ready = 0; ovf_clr = 0;
        model_reset();
        tick("rst");
        tick("rst");
        chk("rst_valid", valid_o, 0);
        chk("rst_code", code_o, 0);
        chk("rst_a_n", a_n_o, 3'b111);
        chk("rst_gs_n", gs_n_o, 1);
        chk("rst_eo_n", eo_n_o, 1);
        chk("rst_ovf", ovf_o, 0);
        rst = 0;
        tick("post_rst");

        // 1: latency and single event while held low
        in_n = 8'hFB;
        for (int i = 0; i < 3; i++) begin
            tick("t1_wait");
            chk("t1_early_valid", valid_o, 0);
        end
        tick("t1_rise");
        chk("t1_valid", valid_o, 1);
        chk("t1_code", code_o, 2);
        chk("t1_a_n", a_n_o, 3'b101);
        chk("t1_gs_n", gs_n_o, 0);
        ready = 1;
        tick("t1_acc");
        ready = 0;
        chk("t1_after_valid", valid_o, 0);
        chk("t1_after_eo", eo_n_o, 0);
        for (int i = 0; i < 4; i++) tick("t1_hold");
        chk("t1_noretrig", valid_o, 0);
        idle_lines(3);

        // 2: three simultaneous lines drain back to back
        ready = 1;
        in_n  = 8'h5D;
        for (int i = 0; i < 10; i++) begin
            tick("t2");
            if (valid_o) codes.push_back(int'(code_o));
        end
        chk("t2_count", codes.size(), 3);
        if (codes.size() == 3) begin
            chk("t2_c0", codes[0], 7);
            chk("t2_c1", codes[1], 5);
            chk("t2_c2", codes[2], 1);
        end
        ready = 0;
        idle_lines(3);

        // 3: stall holds code against higher priority arrival
        in_n = 8'hF7;
        for (int i = 0; i < 5; i++) tick("t3_a");
        in_n = 8'hB7;
        for (int i = 0; i < 5; i++) tick("t3_b");
        chk("t3_hold", code_o, 3);
        ready = 1;
        tick("t3_acc");
        chk("t3_next", code_o, 6);
        tick("t3_acc2");
        ready = 0;
        idle_lines(3);

        // 4: disable with pending, capture while disabled, re-enable
        in_n = 8'hEF;
        for (int i = 0; i < 5; i++) tick("t4_a");
        ei_n = 1;
        tick("t4_dis");
        chk("t4_dis_valid", valid_o, 0);
        chk("t4_dis_a_n", a_n_o, 3'b111);
        chk("t4_dis_eo", eo_n_o, 1);
        in_n = 8'hEE;
        for (int i = 0; i < 5; i++) tick("t4_b");
        ei_n = 0;
        tick("t4_en");
        chk("t4_code4", code_o, 4);
        ready = 1;
        tick("t4_acc");
        chk("t4_code0", code_o, 0);
        chk("t4_code0_valid", valid_o, 1);
        tick("t4_acc2");
        ready = 0;
        idle_lines(3);

        // 5: overflow on line 2, clear, coincident set wins
        in_n = 8'hFB; tick("t5_p1");
        idle_lines(4);
        in_n = 8'hFB; tick("t5_p2");
        idle_lines(4);
        chk("t5_ovf", ovf_o, 8'h04);
        ovf_clr = 1; tick("t5_clr"); ovf_clr = 0;
        chk("t5_ovf_clr", ovf_o, 8'h00);
        in_n = 8'hFB; tick("t5_p3");
        in_n = 8'hFF; tick("t5_p3b");
        ovf_clr = 1; tick("t5_coinc"); ovf_clr = 0;
        chk("t5_ovf_win", ovf_o, 8'h04);
        ready = 1; tick("t5_drain"); tick("t5_drain");
        ready = 0;
        ovf_clr = 1; tick("t5_clr2"); ovf_clr = 0;
        idle_lines(3);

        // 6: reset mid-operation, line 5 held through reset
        in_n = 8'hD5;
        for (int i = 0; i < 6; i++) tick("t6_a");
        chk("t6_pre_valid", valid_o, 1);
        in_n = 8'hDF;
        rst = 1;
        tick("t6_rst");
        chk("t6_rst_valid", valid_o, 0);
        chk("t6_rst_code", code_o, 0);
        chk("t6_rst_a_n", a_n_o, 3'b111);
        chk("t6_rst_gs_n", gs_n_o, 1);
        chk("t6_rst_eo_n", eo_n_o, 1);
        chk("t6_rst_ovf", ovf_o, 0);
        rst = 0;
        ready = 1;
        cnt5 = 0;
        for (int i = 0; i < 12; i++) begin
            tick("t6_b");
            if (valid_o && code_o == 3'd5) cnt5++;
        end
        chk("t6_once", cnt5, 1);
        ready = 0;
        idle_lines(3);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(7) == 0) in_n[b] = ~in_n[b];
            ready   = ($urandom_range(2) != 0);
            ei_n    = ($urandom_range(15) == 0);
            ovf_clr = ($urandom_range(19) == 0);
            rst     = ($urandom_range(199) == 0);
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
